multicycle_sequencer: RTL and testbench

Multi-cycle control FSM for the CPU core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB over a single shared instruction/data memory port, and drives the per-state datapath strobes: PC/IR load, memory request, ALU op, mux selects and register write. It sits between the IR/ALU datapath and the memory interface. It replaces per-instruction single-cycle decode with a handshaked sequence.

---
 rtl/cpu_pkg.sv | 51 +++++
 rtl/op_classify.sv | 40 ++++
 rtl/multicycle_sequencer.sv | 174 +++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle CPU control path: opcodes, sequencer
// states, ALU op bases, datapath mux selects and the opcode class bundle.
package cpu_pkg;

  localparam int unsigned OPC_W    = 4;
  localparam int unsigned FUNC_W   = 4;
  localparam int unsigned ALU_OP_W = 6;
  localparam int unsigned SRC_W    = 2;
  localparam int unsigned CNT_W    = 32;

  localparam logic [OPC_W-1:0] OP_ALUR   = 4'd0;
  localparam logic [OPC_W-1:0] OP_CMPR   = 4'd2;
  localparam logic [OPC_W-1:0] OP_SW     = 4'd5;
  localparam logic [OPC_W-1:0] OP_BRANCH = 4'd6;
  localparam logic [OPC_W-1:0] OP_ALUI   = 4'd8;
  localparam logic [OPC_W-1:0] OP_LW     = 4'd9;
  localparam logic [OPC_W-1:0] OP_CMPI   = 4'd10;
  localparam logic [OPC_W-1:0] OP_JAL    = 4'd11;

  localparam logic [ALU_OP_W-1:0] CMP_BASE = 6'd16;
  localparam logic [ALU_OP_W-1:0] JAL_OP   = 6'd32;

  localparam logic [SRC_W-1:0] PC_SRC_PC4    = 2'd0;
  localparam logic [SRC_W-1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [SRC_W-1:0] PC_SRC_ALU    = 2'd2;

  localparam logic [SRC_W-1:0] REG_SRC_ALU = 2'd0;
  localparam logic [SRC_W-1:0] REG_SRC_MEM = 2'd1;
  localparam logic [SRC_W-1:0] REG_SRC_PC  = 2'd2;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  typedef struct packed {
    logic is_alu;
    logic is_imm;
    logic is_load;
    logic is_store;
    logic is_cmp;
    logic is_branch;
    logic is_jal;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/op_classify.sv
// Combinational opcode classifier: turns the IR opcode field into the class
// flags the sequencer branches and strobes on.
module op_classify
  import cpu_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output op_class_t        cls
);

  always_comb begin
    cls = '0;
    unique case (opcode)
      OP_ALUR: cls.is_alu = 1'b1;
      OP_ALUI: begin
        cls.is_alu = 1'b1;
        cls.is_imm = 1'b1;
      end
      OP_CMPR: cls.is_cmp = 1'b1;
      OP_CMPI: begin
        cls.is_cmp = 1'b1;
        cls.is_imm = 1'b1;
      end
      OP_LW: begin
        cls.is_load = 1'b1;
        cls.is_imm  = 1'b1;
      end
      OP_SW: begin
        cls.is_store = 1'b1;
        cls.is_imm   = 1'b1;
      end
      OP_BRANCH: cls.is_branch = 1'b1;
      OP_JAL: begin
        cls.is_jal = 1'b1;
        cls.is_imm = 1'b1;
      end
      default: cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: steps each instruction through FETCH/DECODE/EXEC/
// MEM/WB over one shared memory port and decodes the datapath strobes.
module multicycle_sequencer
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                run,
  input  logic [OPC_W-1:0]    opcode,
  input  logic [FUNC_W-1:0]   func,
  input  logic                alu_cond,
  input  logic                mem_ready,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_addr_src,
  output logic                ir_write,
  output logic                pc_write,
  output logic [SRC_W-1:0]    pc_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_src,
  output logic                reg_write,
  output logic [SRC_W-1:0]    reg_src,
  output logic                instr_done,
  output logic [CNT_W-1:0]    instr_count,
  output logic                trap
);

  state_t                state;
  state_t                state_nxt;
  op_class_t             cls;
  logic                  fetch_busy;
  logic                  fetch_req_c;
  logic [ALU_OP_W-1:0]   alu_op_c;

  op_classify u_op_classify (
    .opcode (opcode),
    .cls    (cls)
  );

  // A fetch that has started waiting keeps requesting even if run drops.
  assign fetch_req_c = run | fetch_busy;

  always_comb begin
    alu_op_c = '0;
    if (cls.is_cmp || cls.is_branch) begin
      alu_op_c = CMP_BASE + ALU_OP_W'(func);
    end else if (cls.is_jal) begin
      alu_op_c = JAL_OP;
    end else if (cls.is_alu || cls.is_load || cls.is_store) begin
      alu_op_c = ALU_OP_W'(func);
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      FETCH: begin
        if (fetch_req_c && mem_ready) begin
          state_nxt = DECODE;
        end
      end
      DECODE: state_nxt = cls.illegal ? TRAP : EXEC;
      EXEC: begin
        if (cls.is_branch) begin
          state_nxt = FETCH;
        end else if (cls.is_load || cls.is_store) begin
          state_nxt = MEM;
        end else begin
          state_nxt = WB;
        end
      end
      MEM: begin
        if (mem_ready) begin
          state_nxt = cls.is_load ? WB : FETCH;
        end
      end
      WB:      state_nxt = FETCH;
      TRAP:    state_nxt = TRAP;
      default: state_nxt = FETCH;
    endcase
  end

  // Strobe decode; everything is forced low while reset is held.
  always_comb begin
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr_src = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_SRC_PC4;
    alu_op       = '0;
    alu_src      = 1'b0;
    reg_write    = 1'b0;
    reg_src      = REG_SRC_ALU;
    instr_done   = 1'b0;
    if (reset_n) begin
      unique case (state)
        FETCH: begin
          mem_read = fetch_req_c;
          if (fetch_req_c && mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            pc_src   = PC_SRC_PC4;
          end
        end
        EXEC: begin
          alu_op  = alu_op_c;
          alu_src = cls.is_imm;
          if (cls.is_branch) begin
            pc_write   = alu_cond;
            pc_src     = PC_SRC_BRANCH;
            instr_done = 1'b1;
          end
        end
        MEM: begin
          mem_addr_src = 1'b1;
          mem_read     = cls.is_load;
          mem_write    = cls.is_store;
          alu_op       = alu_op_c;
          alu_src      = cls.is_imm;
          instr_done   = cls.is_store & mem_ready;
        end
        WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          if (cls.is_load) begin
            reg_src = REG_SRC_MEM;
          end else if (cls.is_jal) begin
            reg_src  = REG_SRC_PC;
            pc_write = 1'b1;
            pc_src   = PC_SRC_ALU;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_busy <= 1'b0;
    end else begin
      fetch_busy <= (state == FETCH) && fetch_req_c && !mem_ready;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^32
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_count <= '0;
    end else if (instr_done) begin
      instr_count <= instr_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trap <= 1'b0;
    end else if (state == DECODE && cls.illegal) begin
      trap <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: per-cycle strobe checks against
// a phase-sequence reference model, directed and randomized instructions.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        run;
  logic [3:0]  opcode;
  logic [3:0]  func;
  logic        alu_cond;
  logic        mem_ready;
  logic        mem_read;
  logic        mem_write;
  logic        mem_addr_src;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic [5:0]  alu_op;
  logic        alu_src;
  logic        reg_write;
  logic [1:0]  reg_src;
  logic        instr_done;
  logic [31:0] instr_count;
  logic        trap;

  int          total = 0;
  int          bad = 0;
  logic [31:0] model_count = '0;

  localparam int R_IDLE  = 0;
  localparam int R_FWAIT = 1;
  localparam int R_FDONE = 2;
  localparam int R_DEC   = 3;
  localparam int R_EXEC  = 4;
  localparam int R_MWAIT = 5;
  localparam int R_MDONE = 6;
  localparam int R_WB    = 7;
  localparam int R_TRAP  = 8;

  multicycle_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .run          (run),
    .opcode       (opcode),
    .func         (func),
    .alu_cond     (alu_cond),
    .mem_ready    (mem_ready),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr_src (mem_addr_src),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .alu_op       (alu_op),
    .alu_src      (alu_src),
    .reg_write    (reg_write),
    .reg_src      (reg_src),
    .instr_done   (instr_done),
    .instr_count  (instr_count),
    .trap         (trap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] obs_vec();
    return {mem_read, mem_write, mem_addr_src, ir_write, pc_write, pc_src,
            alu_op, alu_src, reg_write, reg_src, instr_done, trap};
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return op inside {4'd0, 4'd2, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11};
  endfunction

  // Expected strobes for one cycle, given which phase of the instruction it is.
  function automatic logic [18:0] exp_vec(input int role, input logic [3:0] op,
                                          input logic [3:0] fn, input logic cond);
    logic mr, mw, mas, irw, pcw, als, rw, done, tr;
    logic [1:0] ps, rs;
    logic [5:0] ao, aop;
    logic lw, sw, br, jal, imm, cmpb;
    mr = 0; mw = 0; mas = 0; irw = 0; pcw = 0; als = 0; rw = 0; done = 0; tr = 0;
    ps = 0; rs = 0; ao = 0;
    lw   = (op == 4'd9);
    sw   = (op == 4'd5);
    br   = (op == 4'd6);
    jal  = (op == 4'd11);
    imm  = (op == 4'd8) || lw || sw || (op == 4'd10) || jal;
    cmpb = (op == 4'd2) || (op == 4'd10) || br;
    aop  = jal ? 6'd32 : (cmpb ? 6'd16 + {2'b00, fn} : {2'b00, fn});
    case (role)
      R_FWAIT: mr = 1;
      R_FDONE: begin mr = 1; irw = 1; pcw = 1; end
      R_EXEC: begin
        ao = aop; als = imm;
        if (br) begin pcw = cond; ps = 2'd1; done = 1; end
      end
      R_MWAIT, R_MDONE: begin
        mas = 1; mr = lw; mw = sw; ao = aop; als = imm;
        done = sw && (role == R_MDONE);
      end
      R_WB: begin
        rw = 1; done = 1;
        rs = lw ? 2'd1 : (jal ? 2'd2 : 2'd0);
        if (jal) begin pcw = 1; ps = 2'd2; end
      end
      R_TRAP: tr = 1;
      default: ;
    endcase
    return {mr, mw, mas, irw, pcw, ps, ao, als, rw, rs, done, tr};
  endfunction

  // Drive one cycle's inputs at the falling edge and check outputs just after.
  task automatic step(input int role, input logic [3:0] op, input logic [3:0] fn,
                      input logic cond, input string tag);
    @(negedge clk);
    if (role == R_FWAIT || role == R_FDONE) run = 1'b1;
    else if (role == R_IDLE) run = 1'b0;
    else run = 1'($urandom);
    if (role == R_FWAIT || role == R_MWAIT) mem_ready = 1'b0;
    else if (role == R_FDONE || role == R_MDONE) mem_ready = 1'b1;
    else mem_ready = 1'($urandom);
    if (role == R_IDLE || role == R_FWAIT || role == R_FDONE) begin
      opcode = 4'($urandom);
      func   = 4'($urandom);
    end else begin
      opcode = op;
      func   = fn;
    end
    alu_cond = (role == R_EXEC) ? cond : 1'($urandom);
    #1;
    check($sformatf("%s role%0d", tag, role), 32'(obs_vec()), 32'(exp_vec(role, op, fn, cond)));
  endtask

  task automatic do_instr(input logic [3:0] op, input logic [3:0] fn, input logic cond,
                          input int fw, input int mw, input string tag);
    int roles[$];
    for (int i = 0; i < fw; i++) roles.push_back(R_FWAIT);
    roles.push_back(R_FDONE);
    roles.push_back(R_DEC);
    if (!is_legal(op)) begin
      for (int i = 0; i < 10; i++) roles.push_back(R_TRAP);
    end else begin
      roles.push_back(R_EXEC);
      if (op == 4'd9 || op == 4'd5) begin
        for (int i = 0; i < mw; i++) roles.push_back(R_MWAIT);
        roles.push_back(R_MDONE);
      end
      if (op != 4'd5 && op != 4'd6) roles.push_back(R_WB);
    end
    foreach (roles[i]) step(roles[i], op, fn, cond, tag);
    if (is_legal(op)) begin
      model_count = model_count + 32'd1;
      step(R_IDLE, op, fn, cond, {tag, " idle"});
      check({tag, " count"}, instr_count, model_count);
    end
  endtask

  task automatic reset_pulse(input string tag);
    @(negedge clk);
    reset_n   = 1'b0;
    run       = 1'b1;
    mem_ready = 1'b1;
    #1;
    model_count = '0;
    check({tag, " strobes"}, 32'(obs_vec()), 32'd0);
    check({tag, " count"}, instr_count, model_count);
    @(negedge clk);
    reset_n = 1'b1;
    run     = 1'b0;
  endtask

  initial begin
    logic [3:0] legal [8];
    legal = '{4'd0, 4'd2, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11};
    reset_n   = 1'b0;
    run       = 1'b1;
    mem_ready = 1'b1;
    opcode    = 4'd0;
    func      = 4'd0;
    alu_cond  = 1'b0;
    #1;
    check("reset strobes", 32'(obs_vec()), 32'd0);
    check("reset count", instr_count, 32'd0);
    check("reset trap", 32'(trap), 32'd0);
    run = 1'b0;
    #1 reset_n = 1'b1;

    do_instr(4'd0, 4'd3, 1'b0, 0, 0, "alur");
    do_instr(4'd9, 4'd4, 1'b0, 0, 2, "lw_wait");
    do_instr(4'd6, 4'd1, 1'b1, 0, 0, "br_taken");
    do_instr(4'd6, 4'd1, 1'b0, 0, 0, "br_not");
    do_instr(4'd11, 4'd2, 1'b0, 0, 0, "jal");
    do_instr(4'd5, 4'd7, 1'b0, 2, 1, "sw_wait");
    do_instr(4'd10, 4'd15, 1'b1, 1, 0, "cmpi");

    for (int n = 0; n < 40; n++) begin
      do_instr(legal[$urandom_range(0, 7)], 4'($urandom), 1'($urandom),
               int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
               $sformatf("rnd%0d", n));
    end

    do_instr(4'd15, 4'd0, 1'b0, 0, 0, "trap");
    check("trap count held", instr_count, model_count);
    reset_pulse("trap clear");
    check("trap cleared", 32'(trap), 32'd0);

    // Reset while a store is waiting in MEM: request drops with no retire.
    step(R_FDONE, 4'd5, 4'd1, 1'b0, "sw_rst");
    step(R_DEC, 4'd5, 4'd1, 1'b0, "sw_rst");
    step(R_EXEC, 4'd5, 4'd1, 1'b0, "sw_rst");
    step(R_MWAIT, 4'd5, 4'd1, 1'b0, "sw_rst");
    #2 reset_n = 1'b0;
    #1;
    check("sw_rst mem_write", 32'(mem_write), 32'd0);
    check("sw_rst count", instr_count, model_count);
    @(negedge clk);
    reset_n = 1'b1;
    run     = 1'b0;
    step(R_IDLE, 4'd0, 4'd0, 1'b0, "post_rst");
    check("post_rst count", instr_count, model_count);

    // Counter wrap from all-ones.
    #1 force dut.instr_count = 32'hFFFF_FFFF;
    #1 release dut.instr_count;
    model_count = 32'hFFFF_FFFF;
    do_instr(4'd8, 4'd9, 1'b0, 0, 0, "wrap");
    check("wrap zero", instr_count, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
